// File: rtl/icache_pkg.sv
// Shared constants, FSM state type and address-split helpers for the icache.
package icache_pkg;

  // Instruction returned whenever the cache is not delivering a real word
  localparam logic [31:0] NOP = 32'h2000_0000;

  typedef enum logic {IDLE, MISS} state_t;

  // Byte-offset bits covering one line (word index plus the 2 byte bits)
  function automatic int off_bits(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int set_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int pc_bits, input int line_words, input int sets);
    return pc_bits - off_bits(line_words) - set_bits(sets);
  endfunction

endpackage

// File: rtl/icache_sa_if.sv
// Fetch-side and memory-side signal bundle of the set-associative icache.
interface icache_sa_if #(
  parameter int PC_BITS    = 20,
  parameter int LINE_WORDS = 4,
  parameter int CNT_BITS   = 32
);
  localparam int LIB = PC_BITS - icache_pkg::off_bits(LINE_WORDS);

  logic [PC_BITS-1:0]       F_pc;
  logic                     F_valid;
  logic                     F_flush;
  logic [32*LINE_WORDS-1:0] F_mem_inst;
  logic                     F_mem_valid;
  logic                     Ic_mem_req;
  logic [LIB-1:0]           Ic_mem_addr;
  logic [31:0]              F_inst;
  logic                     F_stall;
  logic [CNT_BITS-1:0]      Ic_hit_cnt;
  logic [CNT_BITS-1:0]      Ic_miss_cnt;

  // Fetch stage plus memory model side
  modport master (
    output F_pc, F_valid, F_flush, F_mem_inst, F_mem_valid,
    input  Ic_mem_req, Ic_mem_addr, F_inst, F_stall, Ic_hit_cnt, Ic_miss_cnt
  );

  // Cache side
  modport slave (
    input  F_pc, F_valid, F_flush, F_mem_inst, F_mem_valid,
    output Ic_mem_req, Ic_mem_addr, F_inst, F_stall, Ic_hit_cnt, Ic_miss_cnt
  );
endinterface

// File: rtl/icache_victim_sel.sv
// Replacement choice for one set: lowest invalid way, else the round-robin pointer.
module icache_victim_sel #(
  parameter int WAYS = 2,
  parameter int RR_W = 1
) (
  input  logic [WAYS-1:0] valid,
  input  logic [RR_W-1:0] ptr,
  output logic [RR_W-1:0] victim,
  output logic            advance
);

  // Scan from the top so the lowest-index invalid way is the one left standing
  always_comb begin
    victim  = ptr;
    advance = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim  = RR_W'(w);
        advance = 1'b0;
      end
    end
  end

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache with miss FSM, critical-word forward and flush.
module icache_sa
  import icache_pkg::*;
#(
  parameter int PC_BITS    = 20,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 4,
  parameter int WAYS       = 2,
  parameter int CNT_BITS   = 32
) (
  input logic        clk,
  input logic        rst,
  icache_sa_if.slave bus
);

  localparam int OFF       = off_bits(LINE_WORDS);
  localparam int SET_BITS  = set_bits(SETS);
  localparam int TAG_BITS  = tag_bits(PC_BITS, LINE_WORDS, SETS);
  localparam int LIB       = PC_BITS - OFF;
  localparam int SET_W     = (SET_BITS > 0) ? SET_BITS : 1;
  localparam int WORD_BITS = OFF - 2;
  localparam int WORD_W    = (WORD_BITS > 0) ? WORD_BITS : 1;
  localparam int RR_W      = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t                   state_reg, state_next;
  logic [LIB-1:0]           miss_line_reg;
  logic                     drop_reg;
  logic [CNT_BITS-1:0]      hit_cnt_reg, miss_cnt_reg;
  logic [WAYS-1:0]          valid_reg [SETS];
  logic [RR_W-1:0]          rr_reg    [SETS];
  logic [TAG_BITS-1:0]      tag_reg   [SETS][WAYS];
  logic [32*LINE_WORDS-1:0] data_reg  [SETS][WAYS];

  logic [LIB-1:0]           pc_line;
  logic [TAG_BITS-1:0]      pc_tag, miss_tag;
  logic [SET_W-1:0]         pc_set, miss_set;
  logic [WORD_W-1:0]        pc_word;
  logic [WAYS-1:0]          hit_vec;
  logic                     hit;
  logic [32*LINE_WORDS-1:0] hit_line;
  logic [RR_W-1:0]          victim, rr_adv;
  logic                     advance, install, fwd;
  logic                     mem_req, stall;
  logic [31:0]              inst;
  logic                     unused_pc;

  assign pc_line   = bus.F_pc[PC_BITS-1:OFF];
  assign pc_tag    = pc_line[LIB-1:SET_BITS];
  assign miss_tag  = miss_line_reg[LIB-1:SET_BITS];
  assign unused_pc = &{1'b0, bus.F_pc[1:0]};

  generate
    if (SET_BITS > 0) begin : g_set
      assign pc_set   = pc_line[SET_W-1:0];
      assign miss_set = miss_line_reg[SET_W-1:0];
    end else begin : g_noset
      assign pc_set   = '0;
      assign miss_set = '0;
    end
    if (WORD_BITS > 0) begin : g_word
      assign pc_word = bus.F_pc[OFF-1:2];
    end else begin : g_noword
      assign pc_word = '0;
    end
  endgenerate

  // Tag compare for every way of the addressed set
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_cmp
      assign hit_vec[gi] = valid_reg[pc_set][gi] && (tag_reg[pc_set][gi] == pc_tag);
    end
  endgenerate
  assign hit = |hit_vec;

  // One-hot line select of the hitting way
  always_comb begin
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) hit_line = hit_line | data_reg[pc_set][w];
    end
  end

  icache_victim_sel #(.WAYS(WAYS), .RR_W(RR_W)) u_victim (
    .valid   (valid_reg[miss_set]),
    .ptr     (rr_reg[miss_set]),
    .victim  (victim),
    .advance (advance)
  );

  assign rr_adv  = (WAYS > 1) ? rr_reg[miss_set] + RR_W'(1) : '0;
  // A flush arriving with the fill kills the fill outright
  assign install = (state_reg == MISS) && bus.F_mem_valid && !drop_reg && !bus.F_flush;
  assign fwd     = install && bus.F_valid && (pc_line == miss_line_reg);

  // Next state and fetch-facing outputs; reset forces the quiet/stalled values
  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    stall      = 1'b0;
    inst       = NOP;
    case (state_reg)
      IDLE: begin
        if (bus.F_valid) begin
          if (hit) begin
            inst = hit_line[{pc_word, 5'b0} +: 32];
          end else begin
            stall      = 1'b1;
            state_next = MISS;
          end
        end
      end
      MISS: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (bus.F_mem_valid) state_next = IDLE;
        if (fwd) begin
          inst  = bus.F_mem_inst[{pc_word, 5'b0} +: 32];
          stall = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!rst) begin
      mem_req = 1'b0;
      stall   = 1'b1;
      inst    = NOP;
    end
  end

  // FSM, latched miss line, drop flag and saturating perf counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      miss_line_reg <= '0;
      drop_reg      <= 1'b0;
      hit_cnt_reg   <= '0;
      miss_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && bus.F_valid) begin
        if (hit) begin
          if (!(&hit_cnt_reg)) hit_cnt_reg <= hit_cnt_reg + 1'b1;
        end else begin
          if (!(&miss_cnt_reg)) miss_cnt_reg <= miss_cnt_reg + 1'b1;
          miss_line_reg <= pc_line;
        end
      end
      if (state_reg == MISS) begin
        if (bus.F_mem_valid) drop_reg <= 1'b0;
        else if (bus.F_flush) drop_reg <= 1'b1;
      end
    end
  end

  // Per-set valid bits and round-robin pointers; flush keeps the pointers
  generate
    for (gi = 0; gi < SETS; gi++) begin : g_set_state
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_reg[gi] <= '0;
          rr_reg[gi]    <= '0;
        end else if (bus.F_flush) begin
          valid_reg[gi] <= '0;
        end else if (install && miss_set == SET_W'(gi)) begin
          valid_reg[gi][victim] <= 1'b1;
          if (advance) rr_reg[gi] <= rr_adv;
        end
      end
    end
  endgenerate

  // Tag and data arrays are written only on install and never reset
  always_ff @(posedge clk) begin
    if (install) begin
      tag_reg[miss_set][victim]  <= miss_tag;
      data_reg[miss_set][victim] <= bus.F_mem_inst;
    end
  end

  assign bus.Ic_mem_req  = mem_req;
  assign bus.Ic_mem_addr = miss_line_reg;
  assign bus.F_inst      = inst;
  assign bus.F_stall     = stall;
  assign bus.Ic_hit_cnt  = hit_cnt_reg;
  assign bus.Ic_miss_cnt = miss_cnt_reg;

endmodule

// File: tb/tb_icache_sa.sv
// Scoreboard bench for icache_sa (4 sets, 2 ways, 4-word lines, 20-bit PC).
module tb_icache_sa;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  icache_sa_if #(.PC_BITS(20), .LINE_WORDS(4), .CNT_BITS(32)) bus ();

  icache_sa #(.PC_BITS(20), .LINE_WORDS(4), .SETS(4), .WAYS(2), .CNT_BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        stall;
    logic [31:0] inst;
    logic        req;
    logic [15:0] addr;
    logic        chk_addr;
    logic [31:0] hits;
    logic [31:0] misses;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: stores the full line index per way, data derived from the line
  logic        m_state;
  logic [15:0] m_miss_line;
  logic        m_drop;
  logic        m_valid [4][2];
  logic [15:0] m_line  [4][2];
  int          m_ptr   [4];
  int          m_hit, m_miss;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, want, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] line, input int k);
    logic [3:0] kk;
    kk = k[3:0];
    return {4'hC, kk, line, 8'h5A};
  endfunction

  function automatic logic [127:0] mem_line(input logic [15:0] line);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word(line, k);
    return l;
  endfunction

  function automatic logic model_hit(input logic [19:0] pc);
    int s;
    s = int'(pc[5:4]);
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_line[s][w] == pc[19:4]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_state = 1'b0; m_miss_line = '0; m_drop = 1'b0; m_hit = 0; m_miss = 0;
    for (int s = 0; s < 4; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < 2; w++) begin m_valid[s][w] = 1'b0; m_line[s][w] = '0; end
    end
  endtask

  task automatic model_expect(input logic v, input logic [19:0] pc, input logic fl,
                              input logic mv, output exp_t e);
    e = '0;
    e.inst = NOP; e.hits = m_hit; e.misses = m_miss;
    if (!m_state) begin
      if (v) begin
        if (model_hit(pc)) e.inst = mem_word(pc[19:4], int'(pc[3:2]));
        else e.stall = 1'b1;
      end
    end else begin
      e.req = 1'b1; e.addr = m_miss_line; e.chk_addr = 1'b1; e.stall = 1'b1;
      if (mv && !m_drop && !fl && v && pc[19:4] == m_miss_line) begin
        e.stall = 1'b0;
        e.inst  = mem_word(pc[19:4], int'(pc[3:2]));
      end
    end
  endtask

  task automatic model_update(input logic v, input logic [19:0] pc, input logic fl, input logic mv);
    int s, w;
    if (!m_state) begin
      if (v) begin
        if (model_hit(pc)) m_hit++;
        else begin m_miss++; m_miss_line = pc[19:4]; m_state = 1'b1; end
      end
    end else if (mv) begin
      if (!m_drop && !fl) begin
        s = int'(m_miss_line[1:0]);
        w = -1;
        for (int i = 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
        if (w < 0) begin w = m_ptr[s]; m_ptr[s] = (m_ptr[s] + 1) % 2; end
        m_valid[s][w] = 1'b1;
        m_line[s][w]  = m_miss_line;
      end
      m_drop = 1'b0; m_state = 1'b0;
    end else if (fl) begin
      m_drop = 1'b1;
    end
    if (fl) for (int i = 0; i < 4; i++) begin m_valid[i][0] = 1'b0; m_valid[i][1] = 1'b0; end
  endtask

  task automatic compare_out();
    exp_t e;
    e = sb.pop_front();
    check("F_stall", 64'(bus.F_stall), 64'(e.stall));
    check("F_inst", 64'(bus.F_inst), 64'(e.inst));
    check("Ic_mem_req", 64'(bus.Ic_mem_req), 64'(e.req));
    if (e.chk_addr) check("Ic_mem_addr", 64'(bus.Ic_mem_addr), 64'(e.addr));
    check("Ic_hit_cnt", 64'(bus.Ic_hit_cnt), 64'(e.hits));
    check("Ic_miss_cnt", 64'(bus.Ic_miss_cnt), 64'(e.misses));
  endtask

  // One clock of stimulus: drive, predict, sample on the falling edge, advance model
  task automatic cyc(input logic v, input logic [19:0] pc, input logic fl, input logic mv);
    exp_t e;
    bus.F_valid = v; bus.F_pc = pc; bus.F_flush = fl; bus.F_mem_valid = mv;
    bus.F_mem_inst = mem_line(m_miss_line);
    model_expect(v, pc, fl, mv, e);
    sb.push_back(e);
    @(negedge clk);
    compare_out();
    $display("cyc v=%0b pc=%05h fl=%0b mv=%0b -> stall=%0b inst=%08h req=%0b addr=%04h",
             v, pc, fl, mv, bus.F_stall, bus.F_inst, bus.Ic_mem_req, bus.Ic_mem_addr);
    @(posedge clk);
    model_update(v, pc, fl, mv);
    #1;
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    rst = 1'b0;
    model_reset();
    repeat (n) begin
      e = '0; e.stall = 1'b1; e.inst = NOP; e.chk_addr = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      compare_out();
      $display("reset -> stall=%0b inst=%08h req=%0b", bus.F_stall, bus.F_inst, bus.Ic_mem_req);
      @(posedge clk);
    end
    #1 rst = 1'b1;
  endtask

  task automatic fill(input logic [19:0] pc, input int lat);
    cyc(1'b1, pc, 1'b0, 1'b0);
    repeat (lat) cyc(1'b1, pc, 1'b0, 1'b0);
    cyc(1'b1, pc, 1'b0, 1'b1);
  endtask

  logic [15:0] pool [8];
  logic [19:0] rpc;
  logic [1:0]  rw;

  initial begin
    bus.F_valid = 1'b1; bus.F_pc = 20'h00010; bus.F_flush = 1'b0;
    bus.F_mem_valid = 1'b0; bus.F_mem_inst = '0;
    model_reset();
    @(posedge clk); #1;
    do_reset(2);

    // idle with F_valid low
    for (int i = 0; i < 3; i++) cyc(1'b0, 20'($urandom) & 20'hFFFFC, 1'b0, 1'b0);

    // cold miss, 3-cycle refill with forward, then hit on the next word
    cyc(1'b1, 20'h00010, 1'b0, 1'b0);
    cyc(1'b1, 20'h00010, 1'b0, 1'b0);
    cyc(1'b1, 20'h00010, 1'b0, 1'b0);
    cyc(1'b1, 20'h00010, 1'b0, 1'b1);
    cyc(1'b1, 20'h00014, 1'b0, 1'b0);
    check("plan_hit_cnt", 64'(bus.Ic_hit_cnt), 64'd1);
    check("plan_miss_cnt", 64'(bus.Ic_miss_cnt), 64'd1);

    // conflict eviction in set 0
    fill(20'h00000, 1);
    fill(20'h00040, 0);
    fill(20'h00080, 2);
    cyc(1'b1, 20'h00040, 1'b0, 1'b0);
    fill(20'h00000, 1);
    cyc(1'b1, 20'h00088, 1'b0, 1'b0);

    // flush during MISS, then re-miss on the same PC
    cyc(1'b1, 20'h00200, 1'b0, 1'b0);
    cyc(1'b1, 20'h00200, 1'b1, 1'b0);
    cyc(1'b1, 20'h00200, 1'b0, 1'b1);
    cyc(1'b1, 20'h00200, 1'b0, 1'b0);
    cyc(1'b1, 20'h00200, 1'b0, 1'b1);

    // flush coincident with refill, and flush in IDLE on a hit
    cyc(1'b1, 20'h00300, 1'b0, 1'b0);
    cyc(1'b1, 20'h00300, 1'b1, 1'b1);
    cyc(1'b1, 20'h00300, 1'b0, 1'b0);
    cyc(1'b1, 20'h00300, 1'b0, 1'b1);
    cyc(1'b1, 20'h00304, 1'b1, 1'b0);
    fill(20'h00304, 0);

    // redirect during MISS
    cyc(1'b1, 20'h00010, 1'b0, 1'b0);
    cyc(1'b1, 20'h00100, 1'b0, 1'b0);
    cyc(1'b1, 20'h00100, 1'b0, 1'b1);
    cyc(1'b1, 20'h00100, 1'b0, 1'b0);
    cyc(1'b1, 20'h00100, 1'b0, 1'b1);
    cyc(1'b1, 20'h00010, 1'b0, 1'b0);

    // reset mid-miss followed by a stray refill
    cyc(1'b1, 20'h00500, 1'b0, 1'b0);
    cyc(1'b1, 20'h00500, 1'b0, 1'b0);
    do_reset(1);
    cyc(1'b0, 20'h00500, 1'b0, 1'b1);
    cyc(1'b1, 20'h00500, 1'b0, 1'b0);
    cyc(1'b1, 20'h00500, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) cyc(1'b0, 20'($urandom) & 20'hFFFFC, 1'b0, 1'b0);

    // random traffic over a small, conflicting line pool
    pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2] = 16'h0004; pool[3] = 16'h0005;
    pool[4] = 16'h0008; pool[5] = 16'h0010; pool[6] = 16'h0011; pool[7] = 16'h0020;
    for (int i = 0; i < 200; i++) begin
      rw  = 2'($urandom_range(0, 3));
      rpc = {pool[$urandom_range(0, 7)], rw, 2'b00};
      cyc($urandom_range(0, 4) != 0, rpc, $urandom_range(0, 24) == 0,
          m_state && ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
